// File: rtl/phase_barrier_sequencer_pkg.sv
// Shared types and sizing helpers for the phase barrier sequencer.
// State encodings are shared with the testbench.
package phase_barrier_sequencer_pkg;

   typedef enum logic [2:0] {
      WAIT_HOST,
      RUN,
      QUIESCE,
      PROCEED,
      DRAIN,
      END
   } pbs_state_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Wide enough that no counter can wrap before its terminal compare.
   function automatic int unsigned cnt_width(input int unsigned q, input int unsigned d,
                                             input int unsigned t);
      return $clog2(max3(q, d, t) + 1);
   endfunction

endpackage

// File: rtl/phase_barrier_sequencer_quiet_timer.sv
// Counts consecutive idle cycles; expired is asserted in the cycle the
// (limit)-th idle cycle is observed.
module phase_barrier_sequencer_quiet_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         act,
   input  logic [W-1:0] limit,
   output logic         expired
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt;

   assign expired = !clear && !act && (cnt == limit - ONE);

   always_ff @(posedge clk) begin
      if (reset || clear || act) begin
         cnt <= '0;
      end else if (!expired) begin
         cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/phase_barrier_sequencer.sv
// Phase sequencer: host gating, barrier release after quiet traffic,
// end-of-sim after a quiet drain, and a per-episode watchdog.
module phase_barrier_sequencer
   import phase_barrier_sequencer_pkg::*;
#(
   parameter int unsigned NUM_IF         = 4,
   parameter int unsigned QUIET_CYCLES   = 16,
   parameter int unsigned DRAIN_CYCLES   = 64,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned PHASE_W        = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               host_is_active,
   input  logic [NUM_IF-1:0]  if_activity,
   input  logic               pci_activity,
   input  logic [NUM_IF-1:0]  if_good,
   input  logic               pci_good,
   input  logic [NUM_IF-1:0]  if_done,
   input  logic               pci_done,
   output logic               barrier_proceed,
   output logic               sim_end,
   output logic               timeout_err,
   output logic [PHASE_W-1:0] phase_count
);

   localparam int unsigned CW = cnt_width(QUIET_CYCLES, DRAIN_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CW_ONE = CW'(1);

   pbs_state_t    state;
   logic [CW-1:0] wd_cnt;
   logic          all_good, none_good, all_done, any_act;
   logic          timer_clear, timer_expired, wd_watched, wd_expired;
   logic [CW-1:0] timer_limit;

   assign all_good  = &{if_good, pci_good};
   assign none_good = ~|{if_good, pci_good};
   assign all_done  = &{if_done, pci_done};
   assign any_act   = |{if_activity, pci_activity};

   // Held clear outside QUIESCE/DRAIN, so every entry starts from zero.
   assign timer_clear = !(state == QUIESCE || state == DRAIN);
   assign timer_limit = (state == DRAIN) ? CW'(DRAIN_CYCLES) : CW'(QUIET_CYCLES);

   assign wd_watched = (state == QUIESCE) || (state == PROCEED) || (state == DRAIN);
   assign wd_expired = (TIMEOUT_CYCLES != 0) && wd_watched &&
                       (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

   phase_barrier_sequencer_quiet_timer #(.W(CW)) u_quiet_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .act     (any_act),
      .limit   (timer_limit),
      .expired (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= WAIT_HOST;
         wd_cnt          <= '0;
         barrier_proceed <= 1'b0;
         sim_end         <= 1'b0;
         timeout_err     <= 1'b0;
         phase_count     <= '0;
      end else begin
         wd_cnt <= wd_watched ? wd_cnt + CW_ONE : '0;
         if (wd_expired) begin
            timeout_err     <= 1'b1;
            barrier_proceed <= 1'b0;
            sim_end         <= 1'b1;
            state           <= END;
         end else begin
            case (state)
               WAIT_HOST: if (host_is_active) state <= RUN;
               RUN: begin
                  if (all_done)      state <= DRAIN;
                  else if (all_good) state <= QUIESCE;
               end
               QUIESCE: begin
                  if (!all_good) begin
                     state <= RUN;
                  end else if (timer_expired) begin
                     state           <= PROCEED;
                     barrier_proceed <= 1'b1;
                     wd_cnt          <= '0;
                  end
               end
               PROCEED: begin
                  if (none_good) begin
                     barrier_proceed <= 1'b0;
                     if (phase_count != '1) phase_count <= phase_count + PHASE_W'(1);
                     state <= RUN;
                  end
               end
               DRAIN: begin
                  if (!all_done) begin
                     state <= RUN;
                  end else if (timer_expired) begin
                     state   <= END;
                     sim_end <= 1'b1;
                  end
               end
               END: ;
               default: state <= WAIT_HOST;
            endcase
         end
      end
   end

endmodule
